// File: rtl/flags_cond.sv
// Architectural flags register with a one-entry condition-evaluation result stage,
// a sticky overflow flag and a saturating overflow-event counter.
module flags_cond (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       upd_valid,
   input  logic [4:0] upd_flags,
   input  logic       cond_valid,
   input  logic [3:0] cond_code,
   output logic       cond_ready,
   output logic       res_valid,
   output logic       res_taken,
   input  logic       res_ready,
   output logic [4:0] flags_q,
   output logic       sticky_ov,
   input  logic       clr_sticky,
   output logic [7:0] ov_count
);

   // flag bit positions within {C, V, P, S, Z}
   localparam int unsigned FZ = 0;
   localparam int unsigned FS = 1;
   localparam int unsigned FP = 2;
   localparam int unsigned FV = 3;
   localparam int unsigned FC = 4;

   logic [4:0] flags_d;
   logic       res_valid_q, res_valid_d;
   logic       res_taken_q, res_taken_d;
   logic       sticky_q, sticky_d;
   logic [7:0] ov_count_q, ov_count_d;

   logic [4:0] eval_flags;
   logic       cond_hit;
   logic       accept;
   logic       ov_evt;

   function automatic logic cond_eval(input logic [3:0] code, input logic [4:0] f);
      logic z, s, p, v, c;
      z = f[FZ];
      s = f[FS];
      p = f[FP];
      v = f[FV];
      c = f[FC];
      case (code)
         4'h0:    cond_eval = z;
         4'h1:    cond_eval = !z;
         4'h2:    cond_eval = c;
         4'h3:    cond_eval = !c;
         4'h4:    cond_eval = s;
         4'h5:    cond_eval = !s;
         4'h6:    cond_eval = v;
         4'h7:    cond_eval = !v;
         4'h8:    cond_eval = c & !z;
         4'h9:    cond_eval = !c | z;
         4'hA:    cond_eval = (s == v);
         4'hB:    cond_eval = (s != v);
         4'hC:    cond_eval = !z & (s == v);
         4'hD:    cond_eval = z | (s != v);
         4'hE:    cond_eval = p;
         default: cond_eval = 1'b1;
      endcase
   endfunction

   assign cond_ready = !res_valid_q | res_ready;
   assign accept     = cond_valid & cond_ready;
   assign ov_evt     = upd_valid & upd_flags[FV];

   // same-cycle flag updates are visible to the evaluation
   assign eval_flags = upd_valid ? upd_flags : flags_q;
   assign cond_hit   = cond_eval(cond_code, eval_flags);

   always_comb begin
      flags_d     = flags_q;
      res_valid_d = res_valid_q;
      res_taken_d = res_taken_q;
      sticky_d    = sticky_q;
      ov_count_d  = ov_count_q;

      if (upd_valid)
         flags_d = upd_flags;

      if (accept) begin
         res_valid_d = 1'b1;
         res_taken_d = cond_hit;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end

      if (ov_evt)
         sticky_d = 1'b1;
      else if (clr_sticky)
         sticky_d = 1'b0;

      // a clear coinciding with an event restarts the count at one
      if (clr_sticky)
         ov_count_d = {7'd0, ov_evt};
      else if (ov_evt && ov_count_q != 8'hFF)
         ov_count_d = ov_count_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q     <= '0;
         res_valid_q <= 1'b0;
         res_taken_q <= 1'b0;
         sticky_q    <= 1'b0;
         ov_count_q  <= '0;
      end else begin
         flags_q     <= flags_d;
         res_valid_q <= res_valid_d;
         res_taken_q <= res_taken_d;
         sticky_q    <= sticky_d;
         ov_count_q  <= ov_count_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_taken = res_taken_q;
   assign sticky_ov = sticky_q;
   assign ov_count  = ov_count_q;

endmodule

// File: tb/tb_flags_cond.sv
// Self-checking bench for flags_cond: directed scenarios plus random traffic,
// all compared against a behavioural model of the flags/condition/result rules.
module tb_flags_cond;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       upd_valid;
   logic [4:0] upd_flags;
   logic       cond_valid;
   logic [3:0] cond_code;
   logic       cond_ready;
   logic       res_valid;
   logic       res_taken;
   logic       res_ready;
   logic [4:0] flags_q;
   logic       sticky_ov;
   logic       clr_sticky;
   logic [7:0] ov_count;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   logic [4:0] m_flags;
   bit         m_rv;
   bit         m_rt;
   bit         m_sticky;
   int         m_cnt;

   flags_cond dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid),
      .upd_flags  (upd_flags),
      .cond_valid (cond_valid),
      .cond_code  (cond_code),
      .cond_ready (cond_ready),
      .res_valid  (res_valid),
      .res_taken  (res_taken),
      .res_ready  (res_ready),
      .flags_q    (flags_q),
      .sticky_ov  (sticky_ov),
      .clr_sticky (clr_sticky),
      .ov_count   (ov_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // condition table: even code of each pair is the base test, odd code its negation
   function automatic bit ref_cond(input int code, input logic [4:0] f);
      bit z, s, p, v, c, b;
      z = f[0]; s = f[1]; p = f[2]; v = f[3]; c = f[4];
      if (code == 15) return 1'b1;
      if (code == 14) return p;
      case (code / 2)
         0: b = z;
         1: b = c;
         2: b = s;
         3: b = v;
         4: b = c && !z;
         5: b = (s == v);
         default: b = !z && (s == v);
      endcase
      return (code % 2) ? !b : b;
   endfunction

   task automatic model_reset();
      m_flags  = '0;
      m_rv     = 0;
      m_rt     = 0;
      m_sticky = 0;
      m_cnt    = 0;
   endtask

   task automatic idle_inputs();
      upd_valid  = 0;
      upd_flags  = '0;
      cond_valid = 0;
      cond_code  = '0;
      res_ready  = 1;
      clr_sticky = 0;
   endtask

   // one clock: check the combinational ready, advance the model on the edge, check state
   task automatic step();
      bit         rdy, ov;
      logic [4:0] ef;
      #1;
      rdy = !m_rv || res_ready;
      chk("cond_ready", cond_ready, rdy);
      @(posedge clk);
      ef = upd_valid ? upd_flags : m_flags;
      if (cond_valid && rdy) begin
         m_rv = 1;
         m_rt = ref_cond(int'(cond_code), ef);
      end else if (res_ready) begin
         m_rv = 0;
      end
      if (upd_valid) m_flags = upd_flags;
      ov = upd_valid && upd_flags[3];
      if (clr_sticky) m_cnt = ov ? 1 : 0;
      else if (ov)    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      if (ov)              m_sticky = 1;
      else if (clr_sticky) m_sticky = 0;
      #1;
      chk("res_valid", res_valid, m_rv);
      if (m_rv) chk("res_taken", res_taken, m_rt);
      chk("flags_q", flags_q, m_flags);
      chk("sticky_ov", sticky_ov, m_sticky);
      chk("ov_count", ov_count, m_cnt);
   endtask

   initial begin
      logic held;
      idle_inputs();
      model_reset();
      rst_n = 0;
      #2;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_taken", res_taken, 0);
      chk("rst_flags", flags_q, 0);
      chk("rst_sticky", sticky_ov, 0);
      chk("rst_count", ov_count, 0);
      chk("rst_ready", cond_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // bypass: flags written and evaluated in the same cycle
      upd_valid = 1; upd_flags = 5'b00001; cond_valid = 1; cond_code = 4'h0;
      step();
      chk("byp_valid", res_valid, 1);
      chk("byp_taken", res_taken, 1);
      chk("byp_flags", flags_q, 5'b00001);

      // signed compare with S=1, V=0
      idle_inputs();
      upd_valid = 1; upd_flags = 5'b00010;
      step();
      idle_inputs();
      cond_valid = 1; cond_code = 4'hB;
      step();
      chk("lt_taken", res_taken, 1);
      cond_code = 4'hA;
      step();
      chk("ge_taken", res_taken, 0);

      // backpressure: result held while consumer stalls
      cond_code = 4'h1; res_ready = 0;
      step();
      held = res_taken;
      cond_code = 4'h0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_ready", cond_ready, 0);
         chk("bp_valid", res_valid, 1);
         chk("bp_stable", res_taken, held);
      end
      res_ready = 1; cond_code = 4'hF;
      step();
      chk("bp_next_valid", res_valid, 1);
      chk("bp_next_taken", res_taken, 1);

      // overflow counter saturation
      idle_inputs();
      for (int i = 0; i < 300; i++) begin
         upd_valid = 1;
         upd_flags = 5'($urandom) | 5'b01000;
         step();
      end
      chk("sat_count", ov_count, 255);
      chk("sat_sticky", sticky_ov, 1);
      clr_sticky = 1; upd_flags = 5'b01000;
      step();
      chk("clr_set_sticky", sticky_ov, 1);
      chk("clr_set_count", ov_count, 1);
      upd_valid = 0; clr_sticky = 1;
      step();
      chk("clr_sticky", sticky_ov, 0);
      chk("clr_count", ov_count, 0);

      // reset while a result is pending and flags are all ones
      idle_inputs();
      upd_valid = 1; upd_flags = 5'b11111; cond_valid = 1; cond_code = 4'h0; res_ready = 0;
      step();
      chk("pre_rst_valid", res_valid, 1);
      chk("pre_rst_flags", flags_q, 5'b11111);
      idle_inputs();
      res_ready = 0;
      #2 rst_n = 0;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_taken", res_taken, 0);
      chk("mid_rst_flags", flags_q, 0);
      chk("mid_rst_sticky", sticky_ov, 0);
      chk("mid_rst_count", ov_count, 0);
      chk("mid_rst_ready", cond_ready, 1);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 4; i++) step();
      chk("post_rst_valid", res_valid, 0);

      // sweep all flag patterns against all codes
      idle_inputs();
      for (int p = 0; p < 32; p++) begin
         for (int c = 0; c < 16; c++) begin
            upd_valid = 1; upd_flags = 5'(p);
            cond_valid = 1; cond_code = 4'(c);
            step();
            if (c == 15) chk("al_taken", res_taken, 1);
         end
      end

      // random traffic
      idle_inputs();
      for (int i = 0; i < 2000; i++) begin
         upd_valid  = ($urandom_range(0, 2) == 0);
         upd_flags  = 5'($urandom);
         cond_valid = ($urandom_range(0, 3) != 0);
         cond_code  = 4'($urandom);
         res_ready  = ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
